// File: rtl/drive_pkg.sv
// Shared definitions for the drive maneuver sequencer: state codes, speed and
// H-bridge direction encodings, and the next-state output decoder.
package drive_pkg;

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_FORWARD  = 3'd1,
    ST_BRAKE    = 3'd2,
    ST_REVERSE  = 3'd3,
    ST_COAST    = 3'd4,
    ST_PIVOT    = 3'd5,
    ST_JUNCTION = 3'd6
  } state_e;

  localparam logic [1:0] SPD_OFF  = 2'b00;
  localparam logic [1:0] SPD_VEER = 2'b01;
  localparam logic [1:0] SPD_FULL = 2'b10;

  // Motor A patterns are {In1,In2}, motor B patterns are {In3,In4}.
  localparam logic [1:0] DIR_OFF   = 2'b00;
  localparam logic [1:0] DIR_A_FWD = 2'b01;
  localparam logic [1:0] DIR_A_REV = 2'b10;
  localparam logic [1:0] DIR_B_FWD = 2'b10;
  localparam logic [1:0] DIR_B_REV = 2'b01;

  typedef struct packed {
    logic [1:0] dir_a;
    logic [1:0] dir_b;
    logic [1:0] spd_a;
    logic [1:0] spd_b;
    logic       busy;
  } drive_out_t;

  function automatic drive_out_t decode_outputs(input state_e s,
                                                input logic   veer_l,
                                                input logic   veer_r);
    drive_out_t o;
    o.dir_a = DIR_OFF;
    o.dir_b = DIR_OFF;
    o.spd_a = SPD_OFF;
    o.spd_b = SPD_OFF;
    o.busy  = 1'b0;
    case (s)
      ST_FORWARD: begin
        o.dir_a = DIR_A_FWD;
        o.dir_b = DIR_B_FWD;
        // Both veer inputs together are treated as no correction.
        o.spd_a = (veer_l && !veer_r) ? SPD_VEER : SPD_FULL;
        o.spd_b = (veer_r && !veer_l) ? SPD_VEER : SPD_FULL;
      end
      ST_REVERSE: begin
        o.dir_a = DIR_A_REV;
        o.dir_b = DIR_B_REV;
        o.spd_a = SPD_FULL;
        o.spd_b = SPD_FULL;
        o.busy  = 1'b1;
      end
      ST_PIVOT: begin
        o.dir_a = DIR_A_FWD;
        o.dir_b = DIR_B_REV;
        o.spd_a = SPD_VEER;
        o.spd_b = SPD_VEER;
        o.busy  = 1'b1;
      end
      ST_JUNCTION: begin
        o.dir_a = DIR_A_FWD;
        o.dir_b = DIR_B_FWD;
        o.spd_a = SPD_FULL;
        o.spd_b = SPD_FULL;
        o.busy  = 1'b1;
      end
      ST_BRAKE, ST_COAST: o.busy = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/drive_sequencer_debounce.sv
// Level debouncer: out is high once in has been high for CYCLES consecutive
// clock cycles; a single low cycle clears the saturating count.
module debounce #(
  parameter int CYCLES = 50_000
) (
  input  logic clock,
  input  logic resetN,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (in) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = (cnt_q == CNT_MAX);

endmodule

// File: rtl/drive_sequencer.sv
// Two-motor maneuver controller: line following, junction crossing and the
// brake/reverse/coast/pivot collision recovery, timed by one dwell counter.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int TIMER_W         = 26,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int BRAKE_CYCLES    = 5_000_000,
  parameter int REVERSE_CYCLES  = 25_000_000,
  parameter int COAST_CYCLES    = 2_500_000,
  parameter int PIVOT_CYCLES    = 20_000_000,
  parameter int JUNCTION_CYCLES = 10_000_000
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       run,
  input  logic       collision,
  input  logic       junction,
  input  logic       veerLeft,
  input  logic       veerRight,
  output logic       hbIn1,
  output logic       hbIn2,
  output logic       hbIn3,
  output logic       hbIn4,
  output logic [1:0] speedSelA,
  output logic [1:0] speedSelB,
  output logic [2:0] state,
  output logic       busy,
  output logic [7:0] junctionCount
);

  localparam logic [TIMER_W-1:0] BRAKE_LD    = TIMER_W'(BRAKE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REVERSE_LD  = TIMER_W'(REVERSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] COAST_LD    = TIMER_W'(COAST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PIVOT_LD    = TIMER_W'(PIVOT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] JUNCTION_LD = TIMER_W'(JUNCTION_CYCLES - 1);

  logic               coll_db;
  logic               expired;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         jcnt_q, jcnt_d;
  drive_out_t         out_q, out_d;

  debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_coll_debounce (
    .clock (clock),
    .resetN(resetN),
    .in    (collision),
    .out   (coll_db)
  );

  assign expired = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    jcnt_d  = jcnt_q;
    if (!run) begin
      state_d = ST_STOP;
    end else begin
      case (state_q)
        ST_STOP:    state_d = ST_FORWARD;
        ST_FORWARD: begin
          if (coll_db) begin
            state_d = ST_BRAKE;
          end else if (junction) begin
            state_d = ST_JUNCTION;
            jcnt_d  = jcnt_q + 8'd1;
          end
        end
        ST_BRAKE:   if (expired) state_d = ST_REVERSE;
        ST_REVERSE: if (expired) state_d = ST_COAST;
        ST_COAST:   if (expired) state_d = ST_PIVOT;
        // A bumper still pressed after the pivot restarts the recovery.
        ST_PIVOT:   if (expired) state_d = coll_db ? ST_BRAKE : ST_FORWARD;
        ST_JUNCTION: begin
          if (coll_db) begin
            state_d = ST_BRAKE;
          end else if (expired) begin
            state_d = ST_FORWARD;
          end
        end
        default:    state_d = ST_STOP;
      endcase
    end
  end

  // Load N-1 on every state change so a timed state lasts exactly N cycles;
  // untimed states (and aborts to STOP) leave the timer at zero.
  always_comb begin
    timer_d = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_BRAKE:    timer_d = BRAKE_LD;
        ST_REVERSE:  timer_d = REVERSE_LD;
        ST_COAST:    timer_d = COAST_LD;
        ST_PIVOT:    timer_d = PIVOT_LD;
        ST_JUNCTION: timer_d = JUNCTION_LD;
        default:     timer_d = '0;
      endcase
    end else if (!expired) begin
      timer_d = timer_q - 1'b1;
    end
  end

  assign out_d = decode_outputs(state_d, veerLeft, veerRight);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_STOP;
      timer_q <= '0;
      jcnt_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      jcnt_q  <= jcnt_d;
      out_q   <= out_d;
    end
  end

  assign {hbIn1, hbIn2} = out_q.dir_a;
  assign {hbIn3, hbIn4} = out_q.dir_b;
  assign speedSelA      = out_q.spd_a;
  assign speedSelB      = out_q.spd_b;
  assign busy           = out_q.busy;
  assign state          = state_q;
  assign junctionCount  = jcnt_q;

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Maneuver controller for the two-motor H-bridge drive. It arbitrates the line-follow sensors (veer left/right), the junction sensor and the front collision bumper. It sequences timed maneuvers: brake, reverse, coast, pivot and junction crossing. Its outputs are H-bridge direction pins plus a per-motor speed select, which the downstream PWM gating turns into hbEnA/hbEnB.

## Interface
Parameters (all in 50 MHz clock cycles; each must be ≥1 and <2^TIMER_W):
- TIMER_W, 26, dwell-timer width
- DEBOUNCE_CYCLES, 50_000, consecutive high cycles before collision is accepted (1 ms)
- BRAKE_CYCLES, 5_000_000, all-off dwell after collision (100 ms)
- REVERSE_CYCLES, 25_000_000, both motors reverse, full speed
- COAST_CYCLES, 2_500_000, all-off dead time before direction change
- PIVOT_CYCLES, 20_000_000, motor A forward, motor B reverse, veer speed
- JUNCTION_CYCLES, 10_000_000, straight full-speed crossing with veer ignored

Ports:
- clock  in  1  system clock, 50 MHz
- resetN  in  1  asynchronous, active-low reset
- run  in  1  drive enable; low forces STOP
- collision  in  1  bumper, raw level (synchronous to clock)
- junction  in  1  junction sensor, level
- veerLeft  in  1  line drifting right, slow motor A
- veerRight  in  1  line drifting left, slow motor B
- hbIn1, hbIn2, hbIn3, hbIn4  out  1 each  H-bridge direction pins
- speedSelA, speedSelB  out  2 each  00 OFF, 01 VEER, 10 FULL (11 unused)
- state  out  3  current state code
- busy  out  1  high in BRAKE/REVERSE/COAST/PIVOT/JUNCTION
- junctionCount  out  8  junctions entered, wraps 255→0

## Operation
- States: STOP=0, FORWARD=1, BRAKE=2, REVERSE=3, COAST=4, PIVOT=5, JUNCTION=6. Code 7 is illegal and recovers to STOP.
- Direction encoding:
  - A forward: In1=0, In2=1. A reverse: In1=1, In2=0.
  - B forward: In3=1, In4=0. B reverse: In3=0, In4=1.
  - STOP, BRAKE and COAST drive In1–In4 = 0000 with both speeds OFF.
- STOP: run=1 → FORWARD.
- FORWARD transitions, priority collDb > junction > veer:
  - collDb → BRAKE.
  - junction → JUNCTION; junctionCount increments.
  - Otherwise the state stays in FORWARD with both forward, and speeds follow the veer inputs:
    - veerLeft only: A=VEER, B=FULL.
    - veerRight only: A=FULL, B=VEER.
    - Neither or both: FULL/FULL.
- JUNCTION: both forward FULL, veer ignored. collDb → BRAKE (preempts). Timer expiry → FORWARD.
- Collision maneuver sequence: BRAKE → REVERSE (both reverse FULL) → COAST → PIVOT → FORWARD. Collision is ignored inside this sequence.
- At PIVOT expiry, if collDb is still high, go to BRAKE instead of FORWARD.
- Junction is not counted while busy in a collision maneuver.
- run=0 in any state → STOP on the next edge. The timer is cleared and any maneuver is aborted, not resumed.
- Debounce: collDb asserts after collision has been high for DEBOUNCE_CYCLES consecutive cycles. It drops on the first low cycle. The debounce count saturates and runs in all states.

## Timing
- Reset values: state=STOP, hbIn1–4=0, speedSelA/B=OFF, busy=0, junctionCount=0, timer=0, debounce count=0.
- All outputs are registered and decoded from next-state. They change on the same edge as the state register, and output latency from a sampled input is 1 cycle.
- Timed states last exactly N cycles: load N−1 on entry, leave on the edge where timer==0.
- Collision: FORWARD is left on the edge after collision has been sampled high for DEBOUNCE_CYCLES cycles.
- Simultaneous collDb and junction in FORWARD: BRAKE wins and junctionCount is not incremented.
- Reset asserted mid-maneuver returns all outputs to reset values immediately (asynchronous). After release the block starts in STOP.

## Structure
- Shared package drive_pkg holds:
  - state codes
  - speed-select codes (SPD_OFF, SPD_VEER, SPD_FULL)
  - direction pin patterns (DIR_A_FWD, DIR_A_REV, DIR_B_FWD, DIR_B_REV)
- Sub-module debounce: parameter CYCLES; ports clock, resetN, in, out. One instance for collision.
- Single dwell down-counter of TIMER_W bits, shared by all timed states.

## Test plan
Short parameters: DEBOUNCE=3, BRAKE=4, REVERSE=8, COAST=2, PIVOT=6, JUNCTION=5.
- Reset, then run=1 with no sensors → state 0 for 1 cycle, then 1; In=0110; speeds 10/10.
- veerLeft=1 → next edge speedSelA=01, B=10. Assert both veers → 10/10.
- Collision pulse 2 cycles → no transition. Collision held 3 cycles → BRAKE for 4 cycles, then REVERSE 8 (In=1001, 10/10), COAST 2 (0000), PIVOT 6 (In=0101, 01/01), then FORWARD.
- junction in FORWARD → JUNCTION for 5 cycles, junctionCount 0→1, veer ignored. Collision held during JUNCTION → BRAKE after debounce. Count 255 + junction → 0.
- Collision still high at PIVOT expiry → BRAKE directly. run=0 during REVERSE → STOP next edge, outputs 0000/OFF.
- resetN pulsed low mid-PIVOT → outputs clear without a clock edge. After release the state is STOP.
